doom_screen_blitter: RTL and testbench

//  Downstream of the patch-drawing engine: copies the 320x200 8-bit palettised DOOM screen (screens[0] in SDRAM)
//  to the 16-bit RGB565 VGA pixel buffer, translating each index through a 256-entry palette loaded by the HPS.

---
 rtl/doom_pkg.sv | 22 ++
 rtl/doom_palette_ram.sv | 37 +++
 rtl/doom_screen_blitter.sv | 141 ++++++++++++++
 tb/tb_doom_screen_blitter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/doom_pkg.sv
// Shared DOOM accelerator definitions: screen geometry and the blitter state encoding
// (the encoding is visible on debug_seg_export).
package doom_pkg;

    localparam int SCREENWIDTH   = 320;
    localparam int SCREENHEIGHT  = 200;
    localparam int VGA_ROW_SHIFT = 10;

    typedef enum logic [2:0] {
        BLT_IDLE = 3'd0,
        BLT_RD   = 3'd1,
        BLT_LU   = 3'd2,
        BLT_WR   = 3'd3,
        BLT_ADV  = 3'd4,
        BLT_DONE = 3'd5
    } blt_state_e;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        return word[8*k +: 8];
    endfunction

endpackage

// File: rtl/doom_palette_ram.sv
// 256x16 palette: one HPS write port, one registered read port. A collision returns the
// old entry because the read samples the array before the same-edge write lands.
module doom_palette_ram
    import doom_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [7:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic        re_i,
    input  logic [7:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [0:255];
    logic [15:0] rdata_q;

    // Contents deliberately survive reset; the HPS loads them once.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read only on request so the output stays put while the VGA master is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/doom_screen_blitter.sv
// Copies the 8-bit palettised DOOM screen to the RGB565 VGA buffer: one 4-pixel source
// read, then a palette lookup and one VGA write per pixel.
module doom_screen_blitter
    import doom_pkg::*;
#(
    parameter int SCR_W      = SCREENWIDTH,
    parameter int SCR_H      = SCREENHEIGHT,
    parameter int VGA_ROW_SH = VGA_ROW_SHIFT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] w_mem_address,
    output logic        w_mem_read,
    input  logic        w_mem_waitrequest,
    input  logic [31:0] w_mem_readdata,
    output logic [31:0] vga_address,
    output logic        vga_write,
    output logic [15:0] vga_writedata,
    input  logic        vga_waitrequest,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [15:0] pal_wdata,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    input  logic        start,
    output logic        processing,
    output logic [6:0]  debug_seg_export
);

    localparam logic [8:0] X_END  = 9'(SCR_W);
    localparam logic [7:0] Y_LAST = 8'(SCR_H - 1);

    blt_state_e  state_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [31:0] vga_addr_q;
    logic [31:0] pix_word_q;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [1:0]  k_q;
    logic [15:0] pal_rdata;

    doom_palette_ram u_pal (
        .clk     (clk),
        .reset   (reset),
        .we_i    (pal_we),
        .waddr_i (pal_addr),
        .wdata_i (pal_wdata),
        .re_i    (state_q == BLT_LU),
        .raddr_i (byte_lane(pix_word_q, k_q)),
        .rdata_o (pal_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BLT_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            vga_addr_q <= '0;
            pix_word_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
        end else begin
            case (state_q)
                BLT_IDLE: begin
                    if (start) begin
                        src_q   <= src_base & ~32'd3;
                        dst_q   <= dst_base;
                        x_q     <= '0;
                        y_q     <= '0;
                        k_q     <= '0;
                        state_q <= BLT_RD;
                    end
                end
                BLT_RD: begin
                    if (!w_mem_waitrequest) begin
                        pix_word_q <= w_mem_readdata;
                        k_q        <= '0;
                        state_q    <= BLT_LU;
                    end
                end
                BLT_LU: begin
                    vga_addr_q <= dst_q + (32'(y_q) << VGA_ROW_SH) + (32'(x_q) << 1);
                    state_q    <= BLT_WR;
                end
                BLT_WR: begin
                    if (!vga_waitrequest) begin
                        x_q <= x_q + 9'd1;
                        if (k_q != 2'd3) begin
                            k_q     <= k_q + 2'd1;
                            state_q <= BLT_LU;
                        end else begin
                            state_q <= BLT_ADV;
                        end
                    end
                end
                BLT_ADV: begin
                    // Source is contiguous, so the word pointer steps by 4 across row ends too.
                    if (x_q == X_END) begin
                        x_q <= '0;
                        y_q <= y_q + 8'd1;
                        if (y_q == Y_LAST) begin
                            state_q <= BLT_DONE;
                        end else begin
                            src_q   <= src_q + 32'd4;
                            state_q <= BLT_RD;
                        end
                    end else begin
                        src_q   <= src_q + 32'd4;
                        state_q <= BLT_RD;
                    end
                end
                BLT_DONE: begin
                    if (!start) begin
                        state_q <= BLT_IDLE;
                    end
                end
                default: state_q <= BLT_IDLE;
            endcase
        end
    end

    // Valid/ready: a beat transfers on the edge where the strobe is high and waitrequest is
    // low; until then address, data and strobe come straight from held state registers.
    always_comb begin
        w_mem_read = (state_q == BLT_RD);
        vga_write  = (state_q == BLT_WR);
        case (state_q)
            BLT_IDLE: processing = start;
            BLT_DONE: processing = 1'b0;
            default:  processing = 1'b1;
        endcase
    end

    assign w_mem_address    = src_q;
    assign vga_address      = vga_addr_q;
    assign vga_writedata    = pal_rdata;
    assign debug_seg_export = {4'b0000, state_q};

endmodule

// File: tb/tb_doom_screen_blitter.sv
// Scoreboard bench for doom_screen_blitter on a 320x4 screen: frames with zero and random
// waitrequest, a palette collision, and a mid-frame reset followed by a restart.
module tb_doom_screen_blitter;

    localparam int SCR_W  = 320;
    localparam int SCR_H  = 4;
    localparam int ROW_SH = 10;
    localparam int NPIX   = SCR_W * SCR_H;
    localparam int FRAME_BUDGET = 30000;
    localparam logic [6:0] S_IDLE = 7'd0;
    localparam logic [6:0] S_LU   = 7'd2;
    localparam logic [6:0] S_DONE = 7'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] w_mem_address;
    logic        w_mem_read;
    logic        w_mem_waitrequest = 1'b0;
    logic [31:0] w_mem_readdata = '0;
    logic [31:0] vga_address;
    logic        vga_write;
    logic [15:0] vga_writedata;
    logic        vga_waitrequest = 1'b0;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [15:0] pal_wdata = '0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic        start = 1'b0;
    logic        processing;
    logic [6:0]  debug_seg_export;

    always #5 clk = ~clk;

    doom_screen_blitter #(.SCR_W(SCR_W), .SCR_H(SCR_H), .VGA_ROW_SH(ROW_SH)) dut (
        .clk               (clk),
        .reset             (reset),
        .w_mem_address     (w_mem_address),
        .w_mem_read        (w_mem_read),
        .w_mem_waitrequest (w_mem_waitrequest),
        .w_mem_readdata    (w_mem_readdata),
        .vga_address       (vga_address),
        .vga_write         (vga_write),
        .vga_writedata     (vga_writedata),
        .vga_waitrequest   (vga_waitrequest),
        .pal_we            (pal_we),
        .pal_addr          (pal_addr),
        .pal_wdata         (pal_wdata),
        .src_base          (src_base),
        .dst_base          (dst_base),
        .start             (start),
        .processing        (processing),
        .debug_seg_export  (debug_seg_export)
    );

    logic [7:0]  smem [NPIX];
    logic [15:0] pal_m [256];
    logic [47:0] exp_q [$];
    logic [31:0] cur_src = '0;
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit wait_mode = 1'b0;
    bit rst_req = 1'b1;
    int abort_at = 0;

    int r_cnt = 0;
    int v_cnt = 0;
    bit r_busy = 1'b0;
    bit v_busy = 1'b0;
    bit r_hold = 1'b0;
    bit v_hold = 1'b0;
    logic [31:0] r_hold_addr = '0;
    logic [47:0] v_hold_beat = '0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - cur_src;
        if (off > 32'(NPIX - 4)) return 32'd0;
        return {smem[int'(off) + 3], smem[int'(off) + 2], smem[int'(off) + 1], smem[int'(off)]};
    endfunction

    // Slave models, stability checker and scoreboard monitor. Everything here is decided at
    // the negedge and holds until the next posedge, where the DUT sees it.
    always @(negedge clk) begin
        reset = rst_req || (abort_at != 0 && wr_cnt >= abort_at);

        if (r_hold) check("rd_stable", {15'd0, w_mem_read, w_mem_address}, {15'd0, 1'b1, r_hold_addr});
        if (v_hold) check("wr_stable", {vga_address, vga_writedata}, v_hold_beat);
        if (v_hold) check("wr_strobe_stable", 48'(vga_write), 48'd1);

        w_mem_readdata = rd_word(w_mem_address);
        if (w_mem_read) begin
            if (!r_busy) begin
                r_busy = 1'b1;
                r_cnt  = wait_mode ? int'($urandom_range(0, 5)) : 0;
            end else if (r_cnt > 0) begin
                r_cnt--;
            end
        end else begin
            r_busy = 1'b0;
        end
        w_mem_waitrequest = w_mem_read && (r_cnt > 0);

        if (vga_write) begin
            if (!v_busy) begin
                v_busy = 1'b1;
                v_cnt  = wait_mode ? int'($urandom_range(0, 5)) : 0;
            end else if (v_cnt > 0) begin
                v_cnt--;
            end
        end else begin
            v_busy = 1'b0;
        end
        vga_waitrequest = vga_write && (v_cnt > 0);

        if (w_mem_read && !w_mem_waitrequest && !reset) rd_cnt++;
        if (vga_write && !vga_waitrequest && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vga_extra: got write %0h=%0h expected no write", vga_address, vga_writedata);
            end else begin
                check("vga_pixel", {vga_address, vga_writedata}, exp_q.pop_front());
            end
            wr_cnt++;
        end

        r_hold      = w_mem_read && w_mem_waitrequest && !reset;
        r_hold_addr = w_mem_address;
        v_hold      = vga_write && vga_waitrequest && !reset;
        v_hold_beat = {vga_address, vga_writedata};
    end

    task automatic fill_src();
        for (int y = 0; y < SCR_H; y++)
            for (int x = 0; x < SCR_W; x++)
                smem[y * SCR_W + x] = 8'((x + y) & 255);
    endtask

    task automatic push_pixels(input logic [31:0] db, input int first, input int last);
        for (int p = first; p <= last; p++)
            exp_q.push_back({db + (32'(p / SCR_W) << ROW_SH) + (32'(p % SCR_W) << 1),
                             pal_m[smem[p]]});
    endtask

    task automatic run_frame(input logic [31:0] sb, input logic [31:0] db, input bit collide);
        int rd0, wr0;
        bit done, did;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        done = 1'b0;
        did = 1'b0;
        cur_src  = sb & ~32'd3;
        src_base = sb;
        dst_base = db;
        start    = 1'b1;
        #1;
        check("idle_processing_follows_start", 48'({processing, debug_seg_export}), 48'({1'b1, S_IDLE}));
        @(negedge clk);
        check("busy_processing", 48'(processing), 48'd1);
        for (int c = 0; c < FRAME_BUDGET && !done; c++) begin
            @(negedge clk);
            if (pal_we) pal_we = 1'b0;
            if (collide && !did && debug_seg_export == S_LU) begin
                pal_we    = 1'b1;
                pal_addr  = 8'd5;
                pal_wdata = 16'hBEEF;
                did       = 1'b1;
            end
            if (debug_seg_export == S_DONE) done = 1'b1;
        end
        pal_we = 1'b0;
        check("frame_done", 48'(done), 48'd1);
        check("done_processing", 48'(processing), 48'd0);
        repeat (5) @(negedge clk);
        check("held_start_stays_done", 48'(debug_seg_export), 48'(S_DONE));
        start = 1'b0;
        @(negedge clk);
        check("back_to_idle", 48'(debug_seg_export), 48'(S_IDLE));
        check("read_count", 48'(rd_cnt - rd0), 48'(NPIX / 4));
        check("write_count", 48'(wr_cnt - wr0), 48'(NPIX));
        check("queue_empty", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        int wr0;
        bit hit;

        // Palette is loaded while reset is held: writes must still land.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pal_we    = 1'b1;
            pal_addr  = 8'(i);
            pal_wdata = 16'(i * 257);
            pal_m[i]  = 16'(i * 257);
        end
        @(negedge clk);
        pal_we = 1'b0;
        check("reset_strobes", 48'({w_mem_read, vga_write, processing}), 48'd0);
        check("reset_src_addr", 48'(w_mem_address), 48'd0);
        check("reset_vga_beat", {vga_address, vga_writedata}, 48'd0);
        check("reset_state", 48'(debug_seg_export), 48'(S_IDLE));
        rst_req = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait full frame, (x+y) pattern.
        fill_src();
        push_pixels(32'h0040_0000, 0, NPIX - 1);
        run_frame(32'h0010_0000, 32'h0040_0000, 1'b0);

        // Random waitrequest, unaligned src_base, first word 0x04030201.
        wait_mode = 1'b1;
        smem[0] = 8'd1; smem[1] = 8'd2; smem[2] = 8'd3; smem[3] = 8'd4;
        push_pixels(32'h0080_0000, 0, NPIX - 1);
        run_frame(32'h2000_0103, 32'h0080_0000, 1'b0);
        wait_mode = 1'b0;

        // Palette write to index 5 lands on the same edge as pixel 0's lookup of index 5.
        fill_src();
        smem[0] = 8'd5; smem[1] = 8'd5;
        push_pixels(32'h0000_0000, 0, 0);
        pal_m[5] = 16'hBEEF;
        push_pixels(32'h0000_0000, 1, NPIX - 1);
        run_frame(32'h0000_0000, 32'h0000_0000, 1'b1);

        // Reset after exactly 1000 pixels, then a clean rerun from (0,0).
        push_pixels(32'h0040_0000, 0, NPIX - 1);
        wr0 = wr_cnt;
        cur_src  = 32'h0010_0000;
        src_base = 32'h0010_0000;
        dst_base = 32'h0040_0000;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        abort_at = wr0 + 1000;
        hit = 1'b0;
        for (int c = 0; c < FRAME_BUDGET && !hit; c++) begin
            @(negedge clk);
            if (reset) hit = 1'b1;
        end
        check("abort_reached", 48'(hit), 48'd1);
        rst_req  = 1'b1;
        abort_at = 0;
        @(negedge clk);
        check("abort_strobes", 48'({w_mem_read, vga_write, processing}), 48'd0);
        check("abort_state", 48'(debug_seg_export), 48'(S_IDLE));
        check("abort_vga_addr", 48'(vga_address), 48'd0);
        check("abort_pixels_written", 48'(wr_cnt - wr0), 48'd1000);
        exp_q.delete();
        rst_req = 1'b0;
        @(negedge clk);
        push_pixels(32'h0040_0000, 0, NPIX - 1);
        run_frame(32'h0010_0000, 32'h0040_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
